ntt_stage_scheduler: RTL

// - Sequences the butterfly PE across every stage of an in-place radix-2 DIT NTT.
// - Runs after bit_reverse has filled coefficient RAM and raised its done.
// - Per cycle: issues one butterfly's read addresses (a,b) and twiddle address.
// - Issues the matching write-back addresses PE_LATENCY cycles later.
// - Inserts drain bubbles between stages so no stage reads data the previous stage has not yet written.

---
 rtl/ntt_stage_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ntt_stage_scheduler.sv
// Address and write-back scheduler for an in-place radix-2 DIT NTT: one butterfly per cycle with a drain gap between stages.
// Optional stall input is enabled by defining NTT_SCHED_STALL_EN.
module ntt_stage_scheduler #(
    parameter int RING_SIZE  = 1024,
    parameter int PE_LATENCY = 4,
    localparam int ADDR_W = $clog2(RING_SIZE),
    localparam int STG_W  = $clog2(ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef NTT_SCHED_STALL_EN
    input  logic              stall,
`endif
    output logic              busy,
    output logic              done,
    output logic [STG_W-1:0]  stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-2:0] tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);

    localparam int KW = ADDR_W - 1;
    localparam int DW = $clog2(PE_LATENCY + 1);
    localparam logic [KW-1:0]    K_LAST = KW'(RING_SIZE / 2 - 1);
    localparam logic [STG_W-1:0] S_LAST = STG_W'(ADDR_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t            st, st_n;
    logic [KW-1:0]     k, k_n;
    logic [STG_W-1:0]  s, s_n;
    logic [DW-1:0]     d, d_n;
    logic              rd_q;
    logic              hold;

    logic [ADDR_W-1:0] mask_a, kx, a_n, b_n;
    logic [KW-1:0]     mask_k, tw_n;
    logic [STG_W:0]    sh;

    logic              dl_v [PE_LATENCY];
    logic [ADDR_W-1:0] dl_a [PE_LATENCY];
    logic [ADDR_W-1:0] dl_b [PE_LATENCY];

`ifdef NTT_SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        st_n = st;
        k_n  = k;
        s_n  = s;
        d_n  = d;
        case (st)
            ST_IDLE: begin
                if (start) begin
                    st_n = ST_RUN;
                    k_n  = '0;
                    s_n  = '0;
                end
            end
            ST_RUN: begin
                if (k == K_LAST) begin
                    st_n = ST_DRAIN;
                    d_n  = DW'(PE_LATENCY - 1);
                end else begin
                    k_n = k + KW'(1);
                end
            end
            ST_DRAIN: begin
                if (d == '0) begin
                    if (s == S_LAST) begin
                        st_n = ST_DONE;
                        s_n  = '0;
                    end else begin
                        st_n = ST_RUN;
                        s_n  = s + STG_W'(1);
                        k_n  = '0;
                    end
                end else begin
                    d_n = d - DW'(1);
                end
            end
            ST_DONE: st_n = ST_IDLE;
            default: st_n = ST_IDLE;
        endcase
    end

    // a = (k>>s)*2h + (k&(h-1)) is k with a zero bit inserted at position s
    always_comb begin
        mask_a = (ADDR_W'(1) << s_n) - ADDR_W'(1);
        kx     = ADDR_W'(k_n);
        a_n    = ((kx & ~mask_a) << 1) | (kx & mask_a);
        b_n    = a_n | (ADDR_W'(1) << s_n);
        mask_k = (KW'(1) << s_n) - KW'(1);
        sh     = (STG_W + 1)'(ADDR_W - 1) - (STG_W + 1)'(s_n);
        tw_n   = (k_n & mask_k) << sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_IDLE;
            k         <= '0;
            s         <= '0;
            d         <= '0;
            rd_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            for (int i = 0; i < PE_LATENCY; i++) begin
                dl_v[i] <= 1'b0;
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else if (!hold) begin
            st    <= st_n;
            k     <= k_n;
            s     <= s_n;
            d     <= d_n;
            rd_q  <= (st_n == ST_RUN);
            busy  <= (st_n == ST_RUN) || (st_n == ST_DRAIN);
            done  <= (st_n == ST_DONE);
            stage <= s_n;
            if (st_n == ST_RUN) begin
                rd_addr_a <= a_n;
                rd_addr_b <= b_n;
                tw_addr   <= tw_n;
            end
            // Write-back pipe tracks the read that is currently on the outputs
            dl_v[0] <= rd_q;
            dl_a[0] <= rd_addr_a;
            dl_b[0] <= rd_addr_b;
            for (int i = 1; i < PE_LATENCY; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

    assign rd_en     = rd_q & ~hold;
    assign wr_en     = dl_v[PE_LATENCY-1] & ~hold;
    assign wr_addr_a = dl_a[PE_LATENCY-1];
    assign wr_addr_b = dl_b[PE_LATENCY-1];

endmodule
